operand_stage: RTL

Registered, parametrised operand-build stage between decode and execute of the RV32I core. Per opcode it selects ALU operands A/B plus store data, resolves RAW hazards by forwarding from the EX and WB stages, and holds the result in a valid/ready pipeline register with flush support. It replaces the purely combinational operand mux.

---
 rtl/rv_pkg.sv | 30 +++
 rtl/operand_stage_if.sv | 40 ++++
 rtl/operand_stage_fwd_mux.sv | 39 +++
 rtl/operand_stage.sv | 115 +++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I opcode constants and source-usage helpers for the operand stage.
package rv_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_STORE  = 7'b0100011;

  function automatic logic uses_rs1(input opcode_t opc);
    case (opc)
      OPC_OP_IMM, OPC_OP, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input opcode_t opc);
    case (opc)
      OPC_OP, OPC_BRANCH, OPC_STORE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Decode-side and execute-side valid/ready channels of the operand stage.
interface operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  import rv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  opcode_t         in_opcode;
  logic [REGW-1:0] in_rs1;
  logic [REGW-1:0] in_rs2;
  logic [XLEN-1:0] in_rs1d;
  logic [XLEN-1:0] in_rs2d;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [XLEN-1:0] out_sd;
  opcode_t         out_opcode;
  logic            out_illegal;

  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rs1d, in_rs2d, in_pc, in_imm,
    input  in_ready,
    input  out_valid, out_a, out_b, out_sd, out_opcode, out_illegal,
    output out_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rs1d, in_rs2d, in_pc, in_imm,
    output in_ready,
    output out_valid, out_a, out_b, out_sd, out_opcode, out_illegal,
    input  out_ready
  );

endinterface

// File: rtl/operand_stage_fwd_mux.sv
// Per-source bypass: picks EX, then WB, then register-file data; x0 never bypasses.
// With OPSTAGE_FWD_EN undefined the value is the register-file data and only the hit flag matters.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_wen,
  input  logic [REGW-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            wb_wen,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value,
  output logic            hit
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = ex_wen && (ex_rd == rs) && (rs != '0);
  assign wb_hit = wb_wen && (wb_rd == rs) && (rs != '0);
  assign hit    = ex_hit || wb_hit;

`ifdef OPSTAGE_FWD_EN
  always_comb begin
    value = rf_data;
    if (rs == '0)  value = '0;
    else if (ex_hit) value = ex_data;
    else if (wb_hit) value = wb_data;
  end
`else
  logic unused_data;
  assign unused_data = ^{ex_data, wb_data};
  assign value       = rf_data;
`endif

endmodule

// File: rtl/operand_stage.sv
// Registered operand-build stage between decode and execute with valid/ready and flush.
// OPSTAGE_FWD_EN: defined -> EX/WB bypass; undefined -> interlock on hazards instead.
module operand_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_wen,
  input  logic [REGW-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            wb_wen,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  operand_stage_if.slave  bus
);

  logic [XLEN-1:0] r1, r2;
  logic            hit1, hit2;
  logic            stall, accept;
  logic [XLEN-1:0] a_p0, b_p0;
  logic            ill_p0;

  logic            vld_p1;
  logic [XLEN-1:0] a_p1, b_p1, sd_p1;
  opcode_t         opc_p1;
  logic            ill_p1;

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd1 (
    .rs(bus.in_rs1), .rf_data(bus.in_rs1d),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .value(r1), .hit(hit1)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd2 (
    .rs(bus.in_rs2), .rf_data(bus.in_rs2d),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .value(r2), .hit(hit2)
  );

`ifdef OPSTAGE_FWD_EN
  logic unused_hit;
  assign unused_hit = hit1 ^ hit2;
  assign stall      = 1'b0;
`else
  assign stall = bus.in_valid &&
                 ((uses_rs1(bus.in_opcode) && hit1) || (uses_rs2(bus.in_opcode) && hit2));
`endif

  // p0: operand selection from the decoded instruction
  always_comb begin
    a_p0   = '0;
    b_p0   = '0;
    ill_p0 = 1'b0;
    case (bus.in_opcode)
      OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_STORE: begin
        a_p0 = r1;
        b_p0 = bus.in_imm;
      end
      OPC_OP, OPC_BRANCH: begin
        a_p0 = r1;
        b_p0 = r2;
      end
      OPC_LUI:   a_p0 = bus.in_imm;
      OPC_AUIPC: begin
        a_p0 = bus.in_imm;
        b_p0 = bus.in_pc;
      end
      OPC_JAL: begin
        a_p0 = bus.in_pc;
        b_p0 = XLEN'(4);
      end
      default: ill_p0 = 1'b1;
    endcase
  end

  assign bus.in_ready = (!vld_p1 || bus.out_ready) && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

  // p1: output register toward execute
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      sd_p1  <= '0;
      opc_p1 <= '0;
      ill_p1 <= 1'b0;
    end else begin
      if (flush)              vld_p1 <= 1'b0;
      else if (accept)        vld_p1 <= 1'b1;
      else if (bus.out_ready) vld_p1 <= 1'b0;
      if (accept) begin
        a_p1   <= a_p0;
        b_p1   <= b_p0;
        sd_p1  <= r2;
        opc_p1 <= bus.in_opcode;
        ill_p1 <= ill_p0;
      end
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_a       = a_p1;
  assign bus.out_b       = b_p1;
  assign bus.out_sd      = sd_p1;
  assign bus.out_opcode  = opc_p1;
  assign bus.out_illegal = ill_p1;

endmodule
